// File: rtl/alu_seq_pkg.sv
// Shared encodings for the sequential ALU: operation modes, FSM states and Hack control bundle.
package alu_seq_pkg;
   typedef enum logic [1:0] {
      MODE_HACK = 2'd0,
      MODE_SHL  = 2'd1,
      MODE_SAR  = 2'd2,
      MODE_MUL  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic zx, nx, zy, ny, f, no;
   } hack_ctrl_t;
endpackage

// File: rtl/alu_seq_alu.sv
// Combinational Hack-style ALU (module alu); carry is the adder carry-out, gated by f.
module alu #(
   parameter int BUS_WIDTH = 16
) (
   input  logic [BUS_WIDTH-1:0] x,
   input  logic [BUS_WIDTH-1:0] y,
   input  logic                 zx,
   input  logic                 nx,
   input  logic                 zy,
   input  logic                 ny,
   input  logic                 f,
   input  logic                 no,
   output logic [BUS_WIDTH-1:0] out,
   output logic                 carry
);
   logic [BUS_WIDTH-1:0] xa, ya, sum;
   logic                 co;

   always_comb begin
      xa = zx ? '0 : x;
      if (nx) xa = ~xa;
      ya = zy ? '0 : y;
      if (ny) ya = ~ya;
      {co, sum} = {1'b0, xa} + {1'b0, ya};
      out = f ? sum : (xa & ya);
      if (no) out = ~out;
      carry = co & f;
   end
endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: Hack ops, iterative SHL/SAR and shift-add MUL behind valid/ready handshakes.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int BUS_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           mode,
   input  logic                 zx,
   input  logic                 nx,
   input  logic                 zy,
   input  logic                 ny,
   input  logic                 f,
   input  logic                 no,
   input  logic [BUS_WIDTH-1:0] x,
   input  logic [BUS_WIDTH-1:0] y,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BUS_WIDTH-1:0] out,
   output logic [BUS_WIDTH-1:0] out_hi,
   output logic                 carry,
   output logic                 zr,
   output logic                 ng
);
   localparam int SHAMT_W = $clog2(BUS_WIDTH);
   localparam int CW      = SHAMT_W + 1;

   state_e               state, state_nxt;
   mode_e                mode_r;
   hack_ctrl_t           ctrl_r;
   logic [BUS_WIDTH-1:0] x_r, y_r, hi, lo, hi_nxt, lo_nxt, alu_out;
   logic [BUS_WIDTH:0]   sum;
   logic [CW-1:0]        cnt;
   logic                 alu_carry, c_nxt, last, accept;

   assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
   assign out_valid = (state == DONE);
   assign accept    = in_valid & in_ready;

   alu #(.BUS_WIDTH(BUS_WIDTH)) u_alu (
      .x(x_r), .y(y_r),
      .zx(ctrl_r.zx), .nx(ctrl_r.nx), .zy(ctrl_r.zy), .ny(ctrl_r.ny),
      .f(ctrl_r.f), .no(ctrl_r.no),
      .out(alu_out), .carry(alu_carry)
   );

   // One iteration step; 'last' marks the BUSY cycle whose step result is final.
   always_comb begin
      hi_nxt = hi;
      lo_nxt = lo;
      c_nxt  = 1'b0;
      sum    = '0;
      last   = 1'b1;
      case (mode_r)
         MODE_HACK: begin
            lo_nxt = alu_out;
            c_nxt  = alu_carry;
         end
         MODE_SHL: begin
            last = (cnt <= CW'(1));
            if (cnt != '0) begin
               lo_nxt = {lo[BUS_WIDTH-2:0], 1'b0};
               c_nxt  = lo[BUS_WIDTH-1];
            end
         end
         MODE_SAR: begin
            last = (cnt <= CW'(1));
            if (cnt != '0) begin
               lo_nxt = {lo[BUS_WIDTH-1], lo[BUS_WIDTH-1:1]};
               c_nxt  = lo[0];
            end
         end
         MODE_MUL: begin
            last   = (cnt == CW'(1));
            sum    = {1'b0, hi} + (lo[0] ? {1'b0, x_r} : '0);
            hi_nxt = sum[BUS_WIDTH:1];
            lo_nxt = {sum[0], lo[BUS_WIDTH-1:1]};
            c_nxt  = |sum[BUS_WIDTH:1];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = BUSY;
         BUSY:    if (last) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = accept ? BUSY : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Multiplier sits in lo and is consumed lsb-first while the product shifts in from hi.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_r <= MODE_HACK;
         ctrl_r <= '0;
         x_r    <= '0;
         y_r    <= '0;
         hi     <= '0;
         lo     <= '0;
         cnt    <= '0;
         out    <= '0;
         out_hi <= '0;
         carry  <= 1'b0;
         zr     <= 1'b0;
         ng     <= 1'b0;
      end else if (accept) begin
         mode_r <= mode_e'(mode);
         ctrl_r <= '{zx, nx, zy, ny, f, no};
         x_r    <= x;
         y_r    <= y;
         hi     <= '0;
         lo     <= (mode == MODE_MUL) ? y : x;
         cnt    <= (mode == MODE_MUL) ? CW'(BUS_WIDTH) : {1'b0, y[SHAMT_W-1:0]};
      end else if (state == BUSY) begin
         hi <= hi_nxt;
         lo <= lo_nxt;
         if (cnt != '0) cnt <= cnt - CW'(1);
         if (last) begin
            out    <= lo_nxt;
            out_hi <= (mode_r == MODE_MUL) ? hi_nxt : '0;
            carry  <= c_nxt;
            zr     <= (lo_nxt == '0);
            ng     <= lo_nxt[BUS_WIDTH-1];
         end
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results queued at accept, compared at the output handshake.
module tb_alu_seq;
   localparam int W  = 16;
   localparam int SW = $clog2(W);

   logic         clk = 1'b0, rst = 1'b1;
   logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
   logic [1:0]   mode = '0;
   logic         zx = 0, nx = 0, zy = 0, ny = 0, f = 0, no = 0;
   logic [W-1:0] x = '0, y = '0, out, out_hi;
   logic         carry, zr, ng;

   typedef struct {
      logic [W-1:0] o, hi;
      logic         c, z, n;
      int           lat, acc;
   } exp_t;

   exp_t sb[$];
   int   errs = 0, checks = 0, cyc = 0;
   bit   seen = 0;

   alu_seq #(.BUS_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
      .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .x(x), .y(y),
      .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_hi(out_hi),
      .carry(carry), .zr(zr), .ng(ng)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] m, input logic [5:0] c,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t         e;
      logic [W-1:0] xa, ya;
      logic [W:0]   s;
      logic [2*W-1:0] p;
      int           n;
      e.hi = '0;
      e.c  = 1'b0;
      n    = int'(b[SW-1:0]);
      case (m)
         2'd0: begin
            xa = c[5] ? '0 : a;  if (c[4]) xa = ~xa;
            ya = c[3] ? '0 : b;  if (c[2]) ya = ~ya;
            s  = {1'b0, xa} + {1'b0, ya};
            e.o = c[1] ? s[W-1:0] : (xa & ya);
            if (c[0]) e.o = ~e.o;
            e.c   = s[W] & c[1];
            e.lat = 2;
         end
         2'd1: begin
            e.o   = a << n;
            e.c   = (n == 0) ? 1'b0 : a[W-n];
            e.lat = ((n > 1) ? n : 1) + 1;
         end
         2'd2: begin
            e.o   = W'($signed(a) >>> n);
            e.c   = (n == 0) ? 1'b0 : a[n-1];
            e.lat = ((n > 1) ? n : 1) + 1;
         end
         default: begin
            p     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            e.o   = p[W-1:0];
            e.hi  = p[2*W-1:W];
            e.c   = |e.hi;
            e.lat = W + 1;
         end
      endcase
      e.z   = (e.o == '0);
      e.n   = e.o[W-1];
      e.acc = 0;
      return e;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic issue(input logic [1:0] m, input logic [5:0] c,
                        input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
      exp_t e;
      e = model(m, c, a, b);
      mode = m;
      {zx, nx, zy, ny, f, no} = c;
      x = a;
      y = b;
      in_valid = 1'b1;
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 200) begin
         chk("accept_timeout", 64'(waited), 0);
      end else begin
         e.acc = cyc;
         sb.push_back(e);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || out_valid) && n < 100) begin
         @(posedge clk);
         #1 n++;
      end
      chk("drain", 64'(sb.size()), 0);
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
         end else begin
            if (!seen) chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
            seen = 1;
            if (out_ready) begin
               chk("out", out, sb[0].o);
               chk("out_hi", out_hi, sb[0].hi);
               chk("carry", carry, sb[0].c);
               chk("zr", zr, sb[0].z);
               chk("ng", ng, sb[0].n);
               void'(sb.pop_front());
               seen = 0;
            end
         end
      end
   end

   initial begin
      int w;
      exp_t ea;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out", out, 0);
      chk("rst_out_hi", out_hi, 0);
      chk("rst_flags", {carry, zr, ng}, 0);
      chk("rst_in_ready", in_ready, 1);

      issue(2'd0, 6'b000010, 16'd5, 16'd3, w);          // x+y
      issue(2'd0, 6'b000010, 16'hFFFF, 16'd1, w);       // carry out
      issue(2'd0, 6'b000000, 16'hFFFF, 16'd1, w);       // x&y
      issue(2'd0, 6'b010011, 16'd3, 16'd9, w);          // x-y, negative
      issue(2'd1, 6'b0, 16'h8001, 16'd1, w);
      issue(2'd2, 6'b0, 16'h8001, 16'd4, w);
      issue(2'd1, 6'b0, 16'h8001, 16'd0, w);
      issue(2'd2, 6'b0, 16'h8001, 16'd0, w);
      issue(2'd1, 6'b0, 16'h8001, 16'd15, w);
      issue(2'd2, 6'b0, 16'h4003, 16'd2, w);
      issue(2'd3, 6'b0, 16'hFFFF, 16'hFFFF, w);
      issue(2'd3, 6'b0, 16'd3, 16'd5, w);
      drain();

      // Backpressure, then back-to-back accept on the result handshake.
      out_ready = 1'b0;
      ea = model(2'd3, 6'b0, 16'h1234, 16'h00FF);
      issue(2'd3, 6'b0, 16'h1234, 16'h00FF, w);
      for (int i = 0; i < 40 && !out_valid; i++) begin
         @(posedge clk);
         #1;
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out", {out_hi, out}, {ea.hi, ea.o});
         chk("bp_flags", {carry, zr, ng}, {ea.c, ea.z, ea.n});
      end
      out_ready = 1'b1;
      issue(2'd0, 6'b000111, 16'd20, 16'd7, w);         // y-x
      chk("b2b_same_cycle", 64'(w), 0);
      drain();

      // Abort during MUL busy cycle 7.
      issue(2'd3, 6'b0, 16'hABCD, 16'h1357, w);
      repeat (6) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_out", {out_hi, out}, 0);
      sb.delete();
      seen = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("abort_in_ready", in_ready, 1);
      issue(2'd3, 6'b0, 16'h00C8, 16'h0101, w);
      drain();

      for (int i = 0; i < 24; i++)
         issue(2'($urandom_range(0, 3)), 6'($urandom), 16'($urandom), 16'($urandom), w);
      drain();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
